// File: rtl/self_attention_pkg.sv
// Shared definitions for the self-attention head datapath blocks.
// Holds the default block-to-row geometry, derived widths, the bank
// state encoding and a counter-width helper.
package self_attention_pkg;

   localparam int B2R_WIDTH      = 16;
   localparam int B2R_BLOCK_SIZE = 2;
   localparam int B2R_COL_BLOCKS = 4;
   localparam int B2R_ROW_BANDS  = 4;

   // Width of one full matrix row and of the matrix row index.
   localparam int B2R_ROW_W = B2R_WIDTH * B2R_COL_BLOCKS * B2R_BLOCK_SIZE;
   localparam int B2R_IDX_W = $clog2(B2R_ROW_BANDS * B2R_BLOCK_SIZE);

   // FILL: bank accepts tiles; DRAIN: bank is full and presents rows.
   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } bank_state_e;

   // Counter width for a modulo-n counter, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/b2r_bank.sv
// One row-band buffer: BLOCK_SIZE rows of COL_BLOCKS*BLOCK_SIZE elements.
// Tiles are written one tile-column at a time; rows are read through a
// combinational row mux.
module b2r_bank
   import self_attention_pkg::*;
#(
   parameter int WIDTH      = B2R_WIDTH,
   parameter int BLOCK_SIZE = B2R_BLOCK_SIZE,
   parameter int COL_BLOCKS = B2R_COL_BLOCKS
) (
   input  logic                                    clk,
   input  logic                                    wr_en,
   input  logic [cnt_w(COL_BLOCKS)-1:0]            wr_col,
   input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]  wr_block,
   input  logic [cnt_w(BLOCK_SIZE)-1:0]            rd_row,
   output logic [WIDTH*COL_BLOCKS*BLOCK_SIZE-1:0]  rd_data
);

   localparam int ROW_W = WIDTH * COL_BLOCKS * BLOCK_SIZE;
   localparam int COL_W = cnt_w(COL_BLOCKS);

   logic [ROW_W-1:0] mem [BLOCK_SIZE];

   // Scatter tile element (r,c) into bank row r, column wr_col*BLOCK_SIZE+c.
   // NOTE: the storage array has no reset; contents are only observed after
   // a full band has been written, and out_row is gated while invalid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < COL_BLOCKS; k++) begin
            if (wr_col == COL_W'(k)) begin
               for (int r = 0; r < BLOCK_SIZE; r++) begin
                  for (int c = 0; c < BLOCK_SIZE; c++) begin
                     mem[r][(k*BLOCK_SIZE+c)*WIDTH +: WIDTH] <=
                        wr_block[(r*BLOCK_SIZE+c)*WIDTH +: WIDTH];
                  end
               end
            end
         end
      end
   end

   assign rd_data = mem[rd_row];

endmodule

// File: rtl/b2r_converter.sv
// Block-to-row converter: gathers BLOCK_SIZE x BLOCK_SIZE tiles arriving in
// block-column order and re-emits them as full matrix rows.
// Optional build macro B2R_PINGPONG_EN: two banks so one band can fill
// while the previous band drains; undefined gives a single bank.
module b2r_converter
   import self_attention_pkg::*;
#(
   parameter int WIDTH      = B2R_WIDTH,
   parameter int BLOCK_SIZE = B2R_BLOCK_SIZE,
   parameter int COL_BLOCKS = B2R_COL_BLOCKS,
   parameter int ROW_BANDS  = B2R_ROW_BANDS
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]        in_block,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [WIDTH*COL_BLOCKS*BLOCK_SIZE-1:0]        out_row,
   output logic [cnt_w(ROW_BANDS*BLOCK_SIZE)-1:0]        out_row_idx,
   output logic                                          out_last,
   output logic                                          done
);

   localparam int ROW_W  = WIDTH * COL_BLOCKS * BLOCK_SIZE;
   localparam int IDX_W  = cnt_w(ROW_BANDS * BLOCK_SIZE);
   localparam int COL_W  = cnt_w(COL_BLOCKS);
   localparam int DRW_W  = cnt_w(BLOCK_SIZE);
   localparam int BAND_W = cnt_w(ROW_BANDS);
`ifdef B2R_PINGPONG_EN
   localparam int NUM_BANKS = 2;
`else
   localparam int NUM_BANKS = 1;
`endif

   bank_state_e       state [NUM_BANKS];
   logic [COL_W-1:0]  tile_col;
   logic [DRW_W-1:0]  drain_row;
   logic [BAND_W-1:0] wr_band;
   logic [BAND_W-1:0] rd_band;

   bank_state_e       wr_state;
   bank_state_e       rd_state;
   logic              bank_wr_en [NUM_BANKS];
   logic [ROW_W-1:0]  bank_row   [NUM_BANKS];
   logic [ROW_W-1:0]  rd_row_data;

   logic tile_acc;
   logic row_acc;
   logic band_full;
   logic band_drained;
   logic matrix_drained;

`ifdef B2R_PINGPONG_EN
   logic wr_sel;
   logic rd_sel;

   // Route the write strobe and read data through the selected banks.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_wr_en[b] = tile_acc && (wr_sel == 1'(b));
      end
      wr_state    = state[wr_sel];
      rd_state    = state[rd_sel];
      rd_row_data = bank_row[rd_sel];
   end
`else
   // Single bank: writes and reads always target bank 0.
   always_comb begin
      bank_wr_en[0] = tile_acc;
      wr_state      = state[0];
      rd_state      = state[0];
      rd_row_data   = bank_row[0];
   end
`endif

   // Handshake and band-boundary decodes, all from registered state.
   assign in_ready       = (wr_state == FILL);
   assign out_valid      = (rd_state == DRAIN);
   assign tile_acc       = in_valid && in_ready;
   assign row_acc        = out_valid && out_ready;
   assign band_full      = tile_acc && (tile_col == COL_W'(COL_BLOCKS - 1));
   assign band_drained   = row_acc && (drain_row == DRW_W'(BLOCK_SIZE - 1));
   assign matrix_drained = band_drained && (rd_band == BAND_W'(ROW_BANDS - 1));

   assign out_row     = out_valid ? rd_row_data : '0;
   assign out_row_idx = IDX_W'(IDX_W'(rd_band) * IDX_W'(BLOCK_SIZE) + IDX_W'(drain_row));
   assign out_last    = out_valid && (rd_band == BAND_W'(ROW_BANDS - 1)) &&
                        (drain_row == DRW_W'(BLOCK_SIZE - 1));

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      b2r_bank #(
         .WIDTH      (WIDTH),
         .BLOCK_SIZE (BLOCK_SIZE),
         .COL_BLOCKS (COL_BLOCKS)
      ) u_bank (
         .clk      (clk),
         .wr_en    (bank_wr_en[b]),
         .wr_col   (tile_col),
         .wr_block (in_block),
         .rd_row   (drain_row),
         .rd_data  (bank_row[b])
      );
   end

   // Bank state machines, write/read counters and the done pulse.
   // NOTE: all state here updates with non-blocking assignments so every
   // decode above sees the pre-edge values within the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            state[b] <= FILL;
         end
         tile_col  <= '0;
         drain_row <= '0;
         wr_band   <= '0;
         rd_band   <= '0;
         done      <= 1'b0;
`ifdef B2R_PINGPONG_EN
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
`endif
      end else begin
         done <= matrix_drained;

         if (tile_acc) begin
            tile_col <= band_full ? '0 : tile_col + 1'b1;
         end
         if (band_full) begin
            wr_band <= (wr_band == BAND_W'(ROW_BANDS - 1)) ? '0 : wr_band + 1'b1;
`ifdef B2R_PINGPONG_EN
            state[wr_sel] <= DRAIN;
            wr_sel        <= ~wr_sel;
`else
            state[0]      <= DRAIN;
`endif
         end

         if (row_acc) begin
            drain_row <= band_drained ? '0 : drain_row + 1'b1;
         end
         if (band_drained) begin
            rd_band <= (rd_band == BAND_W'(ROW_BANDS - 1)) ? '0 : rd_band + 1'b1;
`ifdef B2R_PINGPONG_EN
            state[rd_sel] <= FILL;
            rd_sel        <= ~rd_sel;
`else
            state[0]      <= FILL;
`endif
         end
      end
   end

endmodule

// File: tb/tb_b2r_converter.sv
// Scoreboard bench for b2r_converter with a 2x2-tile, 2x2-band geometry.
// Expected rows are queued when the tiles are issued; a negedge monitor
// pops and compares every accepted row, checks stall stability and done.
module tb_b2r_converter;

   localparam int WIDTH      = 16;
   localparam int BLOCK_SIZE = 2;
   localparam int COL_BLOCKS = 2;
   localparam int ROW_BANDS  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_block;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_row;
   logic [1:0]  out_row_idx;
   logic        out_last;
   logic        done;

   typedef struct packed {
      logic [63:0] row;
      logic [1:0]  idx;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   done_cnt = 0;
   int   ready_low_cnt = 0;
   bit   count_ready_low = 1'b0;

   logic        stall_prev = 1'b0;
   logic        last_prev  = 1'b0;
   logic [63:0] held_row   = '0;
   logic [1:0]  held_idx   = '0;

   always #5 clk = ~clk;

   b2r_converter #(
      .WIDTH      (WIDTH),
      .BLOCK_SIZE (BLOCK_SIZE),
      .COL_BLOCKS (COL_BLOCKS),
      .ROW_BANDS  (ROW_BANDS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_block    (in_block),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_row_idx (out_row_idx),
      .out_last    (out_last),
      .done        (done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Four 16-bit elements, first argument in the least significant slot.
   function automatic logic [63:0] v4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic push_row(input logic [63:0] row, input logic [1:0] idx, input logic last);
      exp_t e;
      e.row  = row;
      e.idx  = idx;
      e.last = last;
      exp_q.push_back(e);
   endtask

   // Present a tile; returns at the negedge before the accepting posedge.
   task automatic send_tile(input logic [63:0] blk);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_block = blk;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_total++;
         $display("FAIL send_timeout: in_ready stuck at 0");
      end
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: %0d rows outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic set_out_ready(input logic v);
      @(posedge clk);
      #1 out_ready = v;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  in_ready,    1);
      check({tag, "_out_valid"}, out_valid,   0);
      check({tag, "_out_row"},   out_row,     0);
      check({tag, "_row_idx"},   out_row_idx, 0);
      check({tag, "_out_last"},  out_last,    0);
      check({tag, "_done"},      done,        0);
   endtask

   // Monitor: compare accepted rows, stall stability and the done pulse.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev <= 1'b0;
         last_prev  <= 1'b0;
      end else begin
         if (done) done_cnt <= done_cnt + 1;
         if (done || last_prev) check("done_pulse", done, last_prev);
         if (count_ready_low && !in_ready) ready_low_cnt <= ready_low_cnt + 1;
         if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_row", out_row, held_row);
            check("stall_idx", out_row_idx, held_idx);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL extra_row: got idx %0d row %0h, none expected", out_row_idx, out_row);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("row_data", out_row, e.row);
               check("row_idx", out_row_idx, e.idx);
               check("row_last", out_last, e.last);
            end
         end
         last_prev  <= out_valid && out_ready && out_last;
         stall_prev <= out_valid && !out_ready;
         held_row   <= out_row;
         held_idx   <= out_row_idx;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_block  = '0;
      out_ready = 1'b1;
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Band 0 of matrix, including first-row latency.
      push_row(v4(1, 2, 5, 6), 2'd0, 1'b0);
      push_row(v4(3, 4, 7, 8), 2'd1, 1'b0);
      send_tile(v4(1, 2, 3, 4));
      send_tile(v4(5, 6, 7, 8));
      @(negedge clk);
      in_valid = 1'b0;
      check("latency_valid", out_valid, 1);
      drain();

      // Band 1 completes the matrix: out_last on idx 3, one done pulse.
      done_cnt = 0;
      push_row(v4(9, 10, 13, 14),  2'd2, 1'b0);
      push_row(v4(11, 12, 15, 16), 2'd3, 1'b1);
      send_tile(v4(9, 10, 11, 12));
      send_tile(v4(13, 14, 15, 16));
      idle_in();
      drain();
      check("done_count_matrix1", done_cnt, 1);

      // Back-pressure: consumer stalls for several cycles mid-drain.
      set_out_ready(1'b0);
      push_row(v4(21, 22, 25, 26), 2'd0, 1'b0);
      push_row(v4(23, 24, 27, 28), 2'd1, 1'b0);
      send_tile(v4(21, 22, 23, 24));
      send_tile(v4(25, 26, 27, 28));
      idle_in();
      repeat (5) @(negedge clk);
      check("stall_rows_pending", exp_q.size(), 2);
      set_out_ready(1'b1);
      drain();

      // Reset after one partial tile: outputs clear at once, band restarts.
      send_tile(v4(31, 32, 33, 34));
      idle_in();
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      push_row(v4(41, 42, 45, 46), 2'd0, 1'b0);
      push_row(v4(43, 44, 47, 48), 2'd1, 1'b0);
      send_tile(v4(41, 42, 43, 44));
      send_tile(v4(45, 46, 47, 48));
      idle_in();
      drain();
      push_row(v4(51, 52, 55, 56), 2'd2, 1'b0);
      push_row(v4(53, 54, 57, 58), 2'd3, 1'b1);
      send_tile(v4(51, 52, 53, 54));
      send_tile(v4(55, 56, 57, 58));
      idle_in();
      drain();

      // Continuous input with out_ready high: measure in_ready low cycles.
      @(posedge clk);
      #1 begin
         ready_low_cnt   = 0;
         count_ready_low = 1'b1;
      end
      push_row(v4(61, 62, 65, 66), 2'd0, 1'b0);
      push_row(v4(63, 64, 67, 68), 2'd1, 1'b0);
      push_row(v4(71, 72, 75, 76), 2'd2, 1'b0);
      push_row(v4(73, 74, 77, 78), 2'd3, 1'b1);
      send_tile(v4(61, 62, 63, 64));
      send_tile(v4(65, 66, 67, 68));
      send_tile(v4(71, 72, 73, 74));
      send_tile(v4(75, 76, 77, 78));
      idle_in();
      drain();
      @(posedge clk);
      #1 count_ready_low = 1'b0;
`ifdef B2R_PINGPONG_EN
      check("ready_low_cycles", ready_low_cnt, 0);
`else
      check("ready_low_cycles", ready_low_cnt, 4);
`endif

      // Two back-to-back matrices: indices restart, two done pulses.
      done_cnt = 0;
      push_row(v4(101, 102, 105, 106), 2'd0, 1'b0);
      push_row(v4(103, 104, 107, 108), 2'd1, 1'b0);
      push_row(v4(111, 112, 115, 116), 2'd2, 1'b0);
      push_row(v4(113, 114, 117, 118), 2'd3, 1'b1);
      push_row(v4(201, 202, 205, 206), 2'd0, 1'b0);
      push_row(v4(203, 204, 207, 208), 2'd1, 1'b0);
      push_row(v4(211, 212, 215, 216), 2'd2, 1'b0);
      push_row(v4(213, 214, 217, 218), 2'd3, 1'b1);
      send_tile(v4(101, 102, 103, 104));
      send_tile(v4(105, 106, 107, 108));
      send_tile(v4(111, 112, 113, 114));
      send_tile(v4(115, 116, 117, 118));
      send_tile(v4(201, 202, 203, 204));
      send_tile(v4(205, 206, 207, 208));
      send_tile(v4(211, 212, 213, 214));
      send_tile(v4(215, 216, 217, 218));
      idle_in();
      drain();
      check("done_count_two_matrices", done_cnt, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/b2r_converter.md
# b2r_converter

Block-to-row converter for the self-attention head. It sits directly downstream of the 4-bit right shifter that scales the Qn×Knᵀ product. It collects BLOCK_SIZE×BLOCK_SIZE output tiles arriving in block-column order and re-emits them as full-width matrix rows, one row per handshake, for the row-wise softmax stage.

## Interface
- WIDTH, 16: element width (signed fixed point, passed through unchanged)
- BLOCK_SIZE, 2: tile edge; one input beat carries BLOCK_SIZE² elements
- COL_BLOCKS, 4: tiles per row band; output row holds COL_BLOCKS·BLOCK_SIZE elements
- ROW_BANDS, 4: row bands per matrix; the matrix is ROW_BANDS·BLOCK_SIZE rows
---
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high (fixed)
- in_valid  in  1  tile present
- in_ready  out  1  tile can be accepted
- in_block  in  WIDTH·BLOCK_SIZE²  tile; element (r,c) at [(r·BLOCK_SIZE+c)·WIDTH +: WIDTH]
- out_valid  out  1  row present
- out_ready  in  1  consumer accepts row
- out_row  out  WIDTH·COL_BLOCKS·BLOCK_SIZE  row; column j at [j·WIDTH +: WIDTH]
- out_row_idx  out  $clog2(ROW_BANDS·BLOCK_SIZE)  matrix row index of out_row
- out_last  out  1  qualifies final row of matrix
- done  out  1  one-cycle pulse after final row is accepted

## Operation
- Tile accepted when in_valid && in_ready; the k-th accepted tile of a band (k = 0..COL_BLOCKS-1) is written to bank columns k·BLOCK_SIZE..k·BLOCK_SIZE+BLOCK_SIZE-1, rows 0..BLOCK_SIZE-1.
- After COL_BLOCKS tiles the bank is full; it drains BLOCK_SIZE rows, row r presented on out_row until out_valid && out_ready.
- Bank freed on acceptance of its row BLOCK_SIZE-1.
- Counters: tile column (wraps at COL_BLOCKS), drain row (wraps at BLOCK_SIZE), band counters for write and read (wrap at ROW_BANDS); out_row_idx = read_band·BLOCK_SIZE + drain_row.
- out_last = out_valid when read_band = ROW_BANDS-1 and drain_row = BLOCK_SIZE-1; done pulses the cycle after that row is accepted, all counters then at 0 (next matrix starts seamlessly).
- Per-bank state machine: FILL → (COL_BLOCKS-th tile accepted) → FULL/DRAIN → (last row accepted) → FILL.
- No arithmetic; data bits copied verbatim.

## Timing
- Reset values: in_ready=1, out_valid=0, out_row=0, out_row_idx=0, out_last=0, done=0; all counters and bank flags 0. Bank contents need not be reset.
- Latency: final tile of band accepted in cycle N → out_valid=1 in cycle N+1 with row 0.
- Throughput while draining: one row per cycle with out_ready held high.
- out_valid/out_row/out_row_idx held stable while out_valid && !out_ready.
- in_ready is combinational only on registered state (never on in_valid or out_ready).
- rst mid-operation: partial tiles and undrained rows discarded, outputs return to reset values asynchronously.

## Configuration
- B2R_PINGPONG_EN defined: two banks. Writes target bank wr_sel, reads bank rd_sel; in_ready=1 while bank wr_sel is in FILL. Last tile into one bank and last row out of the other in the same cycle both complete; the freed bank accepts the next tile in the following cycle.
- Undefined: one bank; in_ready=0 from the cycle after the band fills until the cycle after its last row is accepted.

## Structure
- Shared constants (B2R row width, row-index width) and the bank-state enum {FILL, DRAIN} in self_attention_pkg.
- One sub-module: b2r_bank — single BLOCK_SIZE×(COL_BLOCKS·BLOCK_SIZE) register array with tile-column write port and row read mux; instantiated once or twice under B2R_PINGPONG_EN.

## Test plan
- WIDTH=16, BLOCK_SIZE=2, COL_BLOCKS=2, ROW_BANDS=2: tiles {1,2;3,4},{5,6;7,8} → rows [1,2,5,6] idx0, [3,4,7,8] idx1, out_last=0.
- Full matrix, band 2 tiles {9,10;11,12},{13,14;15,16} → rows idx2 [9,10,13,14], idx3 [11,12,15,16] with out_last=1; done pulses next cycle.
- out_ready low 5 cycles during drain → out_row/out_row_idx stable, no row lost or duplicated.
- Continuous in_valid, out_ready=1: with B2R_PINGPONG_EN in_ready never drops; without, in_ready=0 for exactly 2 cycles per band.
- rst asserted after one tile accepted → outputs reset immediately; next two tiles form row band 0 with idx 0.
- Two back-to-back matrices → second matrix's out_row_idx restarts at 0, two done pulses total.
